pad_h_border: RTL and testbench

Multi-flux horizontal border padding actor for the HEVC interpolation path, directly upstream of the filter chain that ends in horizontal border removal. Per flux it reads a block-size token N, then N rows of N pels, and emits each row extended by 3 left and 4 right border pels (N+7 per row), plus one extended-size token N+7 per block. Fluxes share one datapath: at most one flux is served per cycle, tag-multiplexed on the FIFO interfaces.

---
 rtl/pad_h_border_pkg.sv | 15 +
 rtl/pad_h_border_if.sv | 25 ++
 rtl/pad_h_border_flux_sel.sv | 23 ++
 rtl/pad_h_border.sv | 182 ++++++++++++++++++
 tb/tb_pad_h_border.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pad_h_border_pkg.sv
// pad_h_border_pkg: shared types and constants for the horizontal border padding actor.
package pad_h_border_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        BODY  = 2'd2,
        RIGHT = 2'd3
    } pad_state_e;

    localparam int PAD_L = 3;
    localparam int PAD_R = 4;
    localparam int MAX_N = 120;

endpackage

// File: rtl/pad_h_border_if.sv
// pad_h_border_if: multi-flux FIFO handshake interfaces (read side and write side).
// Every data word carries the flux tag in its MSBs.
interface read_interface #(
    parameter int WIDTH = 8,
    parameter int FLUX  = 2
);
    logic [FLUX-1:0]            empty;
    logic [FLUX-1:0]            read;
    logic [FLUX-1:0][WIDTH-1:0] dout;

    modport actor (input empty, input dout, output read);
    modport fifo  (output empty, output dout, input read);
endinterface

interface write_interface #(
    parameter int WIDTH = 8,
    parameter int FLUX  = 2
);
    logic [FLUX-1:0]  full;
    logic             write;
    logic [WIDTH-1:0] din;

    modport actor (input full, output write, output din);
    modport fifo  (output full, input write, input din);
endinterface

// File: rtl/pad_h_border_flux_sel.sv
// pad_h_flux_sel: fixed-priority flux picker, lowest ready index wins.
module pad_h_flux_sel #(
    parameter int FLUX      = 2,
    parameter int TAG_WIDTH = $clog2(FLUX)
) (
    input  logic [FLUX-1:0]      ready,
    output logic [TAG_WIDTH-1:0] tag,
    output logic                 valid
);

    // Scan from the top down so the lowest ready flux is the last to overwrite the tag.
    always_comb begin
        tag   = '0;
        valid = 1'b0;
        for (int f = FLUX - 1; f >= 0; f--) begin
            if (ready[f]) begin
                tag   = TAG_WIDTH'(f);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pad_h_border.sv
// pad_h_border: per-flux horizontal border padding (3 left, 4 right pels per row) with
// one extended-size token per block. Define PAD_H_BORDER_ZERO_EN for zero-valued borders
// instead of edge replication (the last-pel register is then dropped).
module pad_h_border
    import pad_h_border_pkg::*;
#(
    parameter int FLUX            = 2,
    parameter int DATA_WIDTH_PEL  = 16,
    parameter int DATA_WIDTH_SIZE = 7
) (
    input  logic          clk,
    input  logic          rst,
    read_interface.actor  read_port_in_pel,
    read_interface.actor  read_port_size,
    write_interface.actor write_port_out_pel,
    write_interface.actor write_port_ext_size
);

    localparam int TAG_WIDTH = $clog2(FLUX);
    localparam int SW        = DATA_WIDTH_SIZE;
    localparam logic [SW-1:0] MAX_N_W = SW'(MAX_N);
    localparam logic [SW-1:0] EXT_W   = SW'(PAD_L + PAD_R);

    pad_state_e    state_q [FLUX];
    pad_state_e    state_d [FLUX];
    logic [SW-1:0] n_q     [FLUX];
    logic [SW-1:0] n_d     [FLUX];
    logic [SW-1:0] col_q   [FLUX];
    logic [SW-1:0] col_d   [FLUX];
    logic [SW-1:0] row_q   [FLUX];
    logic [SW-1:0] row_d   [FLUX];
    logic [2:0]    pad_q   [FLUX];
    logic [2:0]    pad_d   [FLUX];
`ifndef PAD_H_BORDER_ZERO_EN
    logic [DATA_WIDTH_PEL-1:0] last_q [FLUX];
    logic [DATA_WIDTH_PEL-1:0] last_d [FLUX];
`endif

    logic [FLUX-1:0]           ready;
    logic [TAG_WIDTH-1:0]      sel_tag;
    logic                      sel_valid;
    logic [DATA_WIDTH_PEL-1:0] pel_in;
    logic [DATA_WIDTH_PEL-1:0] right_pel;
    logic [SW-1:0]             size_in;
    logic [SW-1:0]             size_clamped;

    // A flux can make progress only when every FIFO its current state touches allows it.
    always_comb begin
        ready = '0;
        for (int f = 0; f < FLUX; f++) begin
            case (state_q[f])
                IDLE:       ready[f] = !read_port_size.empty[f] && !write_port_ext_size.full[f];
                LEFT, BODY: ready[f] = !read_port_in_pel.empty[f] && !write_port_out_pel.full[f];
                RIGHT:      ready[f] = !write_port_out_pel.full[f];
                default:    ready[f] = 1'b0;
            endcase
        end
    end

    pad_h_flux_sel #(
        .FLUX      (FLUX),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_flux_sel (
        .ready (ready),
        .tag   (sel_tag),
        .valid (sel_valid)
    );

    // Serve the selected flux: drive strobes and compute its next state; others hold.
    always_comb begin
        for (int f = 0; f < FLUX; f++) begin
            state_d[f] = state_q[f];
            n_d[f]     = n_q[f];
            col_d[f]   = col_q[f];
            row_d[f]   = row_q[f];
            pad_d[f]   = pad_q[f];
`ifndef PAD_H_BORDER_ZERO_EN
            last_d[f]  = last_q[f];
`endif
        end
        read_port_in_pel.read     = '0;
        read_port_size.read       = '0;
        write_port_out_pel.write  = 1'b0;
        write_port_out_pel.din    = '0;
        write_port_ext_size.write = 1'b0;
        write_port_ext_size.din   = '0;

        pel_in       = read_port_in_pel.dout[sel_tag][DATA_WIDTH_PEL-1:0];
        size_in      = read_port_size.dout[sel_tag][SW-1:0];
        size_clamped = (size_in > MAX_N_W) ? MAX_N_W : size_in;
`ifdef PAD_H_BORDER_ZERO_EN
        right_pel    = '0;
`else
        right_pel    = last_q[sel_tag];
`endif

        if (sel_valid && !rst) begin
            case (state_q[sel_tag])
                IDLE: begin
                    read_port_size.read[sel_tag] = 1'b1;
                    if (size_in != '0) begin
                        write_port_ext_size.write = 1'b1;
                        write_port_ext_size.din   = {sel_tag, size_clamped + EXT_W};
                        n_d[sel_tag]              = size_clamped;
                        row_d[sel_tag]            = '0;
                        pad_d[sel_tag]            = '0;
                        state_d[sel_tag]          = LEFT;
                    end
                end
                LEFT: begin
                    write_port_out_pel.write = 1'b1;
`ifdef PAD_H_BORDER_ZERO_EN
                    write_port_out_pel.din   = {sel_tag, {DATA_WIDTH_PEL{1'b0}}};
`else
                    write_port_out_pel.din   = {sel_tag, pel_in};
`endif
                    pad_d[sel_tag] = pad_q[sel_tag] + 3'd1;
                    if (pad_q[sel_tag] == 3'(PAD_L - 1)) begin
                        col_d[sel_tag]   = '0;
                        state_d[sel_tag] = BODY;
                    end
                end
                BODY: begin
                    read_port_in_pel.read[sel_tag] = 1'b1;
                    write_port_out_pel.write       = 1'b1;
                    write_port_out_pel.din         = {sel_tag, pel_in};
`ifndef PAD_H_BORDER_ZERO_EN
                    last_d[sel_tag] = pel_in;
`endif
                    col_d[sel_tag] = col_q[sel_tag] + SW'(1);
                    if (col_q[sel_tag] == n_q[sel_tag] - SW'(1)) begin
                        pad_d[sel_tag]   = '0;
                        state_d[sel_tag] = RIGHT;
                    end
                end
                RIGHT: begin
                    write_port_out_pel.write = 1'b1;
                    write_port_out_pel.din   = {sel_tag, right_pel};
                    pad_d[sel_tag] = pad_q[sel_tag] + 3'd1;
                    if (pad_q[sel_tag] == 3'(PAD_R - 1)) begin
                        if (row_q[sel_tag] == n_q[sel_tag] - SW'(1)) begin
                            state_d[sel_tag] = IDLE;
                        end else begin
                            row_d[sel_tag]   = row_q[sel_tag] + SW'(1);
                            pad_d[sel_tag]   = '0;
                            state_d[sel_tag] = LEFT;
                        end
                    end
                end
                default: begin
                    state_d[sel_tag] = IDLE;
                end
            endcase
        end
    end

    // Per-flux state and counters; reset abandons any block in progress.
    always_ff @(posedge clk) begin
        for (int f = 0; f < FLUX; f++) begin
            if (rst) begin
                state_q[f] <= IDLE;
                n_q[f]     <= '0;
                col_q[f]   <= '0;
                row_q[f]   <= '0;
                pad_q[f]   <= '0;
`ifndef PAD_H_BORDER_ZERO_EN
                last_q[f]  <= '0;
`endif
            end else begin
                state_q[f] <= state_d[f];
                n_q[f]     <= n_d[f];
                col_q[f]   <= col_d[f];
                row_q[f]   <= row_d[f];
                pad_q[f]   <= pad_d[f];
`ifndef PAD_H_BORDER_ZERO_EN
                last_q[f]  <= last_d[f];
`endif
            end
        end
    end

endmodule

// File: tb/tb_pad_h_border.sv
// tb_pad_h_border: self-checking bench for pad_h_border with queue-based FIFO models and a
// block-level reference model (honours PAD_H_BORDER_ZERO_EN).
`timescale 1ns/1ps
module tb_pad_h_border;
    import pad_h_border_pkg::*;

    localparam int FLUX   = 2;
    localparam int PW     = 16;
    localparam int SW     = 7;
    localparam int TW     = 1;
    localparam int PEL_W  = PW + TW;
    localparam int SIZE_W = SW + TW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    read_interface  #(.WIDTH(PEL_W),  .FLUX(FLUX)) pel_if ();
    read_interface  #(.WIDTH(SIZE_W), .FLUX(FLUX)) size_if ();
    write_interface #(.WIDTH(PEL_W),  .FLUX(FLUX)) out_if ();
    write_interface #(.WIDTH(SIZE_W), .FLUX(FLUX)) ext_if ();

    pad_h_border #(
        .FLUX            (FLUX),
        .DATA_WIDTH_PEL  (PW),
        .DATA_WIDTH_SIZE (SW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .read_port_in_pel    (pel_if),
        .read_port_size      (size_if),
        .write_port_out_pel  (out_if),
        .write_port_ext_size (ext_if)
    );

    logic [PW-1:0] pel_q   [FLUX][$];
    logic [SW-1:0] size_q  [FLUX][$];
    logic [PW-1:0] exp_out [FLUX][$];
    logic [PW-1:0] got_out [FLUX][$];
    logic [SW-1:0] exp_ext [FLUX][$];
    logic [SW-1:0] got_ext [FLUX][$];

    int checks = 0;
    int passes = 0;
    int cycle  = 0;
    logic [FLUX-1:0] full_force = '0;
    bit rand_stall = 1'b0;
    int first_act [FLUX];
    int last_act [FLUX];
    int first_size_rd [FLUX];
    int last_out [FLUX];

    function automatic logic [PW-1:0] border(input logic [PW-1:0] v);
`ifdef PAD_H_BORDER_ZERO_EN
        return (v & '0);
`else
        return v;
`endif
    endfunction

    task automatic refresh();
        for (int f = 0; f < FLUX; f++) begin
            pel_if.empty[f]  = (pel_q[f].size() == 0) || (rand_stall && $urandom_range(0, 3) == 0);
            pel_if.dout[f]   = (pel_q[f].size() > 0) ? {TW'(f), pel_q[f][0]} : '0;
            size_if.empty[f] = (size_q[f].size() == 0) || (rand_stall && $urandom_range(0, 3) == 0);
            size_if.dout[f]  = (size_q[f].size() > 0) ? {TW'(f), size_q[f][0]} : '0;
            out_if.full[f]   = full_force[f] || (rand_stall && $urandom_range(0, 3) == 0);
            ext_if.full[f]   = rand_stall && $urandom_range(0, 4) == 0;
        end
    endtask

    task automatic note_act(input int f);
        if (first_act[f] < 0) first_act[f] = cycle;
        last_act[f] = cycle;
    endtask

    // FIFO models: transactions seen at negedge complete on the following posedge.
    initial begin
        int t;
        refresh();
        forever begin
            @(negedge clk);
            cycle++;
            for (int f = 0; f < FLUX; f++) begin
                if (pel_if.read[f]) begin
                    if (pel_q[f].size() > 0) void'(pel_q[f].pop_front());
                    note_act(f);
                end
                if (size_if.read[f]) begin
                    if (size_q[f].size() > 0) void'(size_q[f].pop_front());
                    if (first_size_rd[f] < 0) first_size_rd[f] = cycle;
                    note_act(f);
                end
            end
            if (out_if.write) begin
                t = int'(out_if.din[PEL_W-1]);
                got_out[t].push_back(out_if.din[PW-1:0]);
                last_out[t] = cycle;
                note_act(t);
            end
            if (ext_if.write) begin
                t = int'(ext_if.din[SIZE_W-1]);
                got_ext[t].push_back(ext_if.din[SW-1:0]);
                note_act(t);
            end
            @(posedge clk);
            #1;
            refresh();
        end
    end

    // Reference model: one block = size token, N*N pels, expected padded rows.
    task automatic applyStimulus(input int f, input int n, input int base);
        int nc;
        logic [PW-1:0] row[$];
        logic [PW-1:0] v;
        size_q[f].push_back(SW'(n));
        if (n == 0) return;
        nc = (n > MAX_N) ? MAX_N : n;
        exp_ext[f].push_back(SW'(nc + PAD_L + PAD_R));
        for (int r = 0; r < nc; r++) begin
            row.delete();
            for (int c = 0; c < nc; c++) begin
                v = (base < 0) ? PW'($urandom) : PW'(base + c);
                row.push_back(v);
                pel_q[f].push_back(v);
            end
            for (int k = 0; k < PAD_L; k++) exp_out[f].push_back(border(row[0]));
            for (int c = 0; c < nc; c++) exp_out[f].push_back(row[c]);
            for (int k = 0; k < PAD_R; k++) exp_out[f].push_back(border(row[nc-1]));
        end
    endtask

    task automatic clear_all();
        for (int f = 0; f < FLUX; f++) begin
            pel_q[f].delete();   size_q[f].delete();
            exp_out[f].delete(); got_out[f].delete();
            exp_ext[f].delete(); got_ext[f].delete();
            first_act[f] = -1;   last_act[f] = -1;
            first_size_rd[f] = -1; last_out[f] = -1;
        end
        full_force = '0;
        rand_stall = 1'b0;
    endtask

    task automatic wait_drained(input int budget, output bit ok);
        bit done;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            done = 1'b1;
            for (int f = 0; f < FLUX; f++) begin
                if (pel_q[f].size() != 0 || size_q[f].size() != 0) done = 1'b0;
                if (got_out[f].size() < exp_out[f].size()) done = 1'b0;
                if (got_ext[f].size() < exp_ext[f].size()) done = 1'b0;
            end
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (5) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        bit ok;
        clear_all();
        applyStimulus(0, 2, -1);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({size_if.read, pel_if.read, out_if.write, ext_if.write} !== 6'b0)
                $display("[TB] FAIL reset_strobes: got %b expected 000000",
                         {size_if.read, pel_if.read, out_if.write, ext_if.write});
            else passes++;
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (size_if.read[0] !== 1'b1 || out_if.write !== 1'b0)
            $display("[TB] FAIL reset_idle_first: size_read %b out_write %b expected 1 0",
                     size_if.read[0], out_if.write);
        else passes++;
        wait_drained(200, ok);
        checks++;
        if (!ok) $display("[TB] FAIL reset_drain: got timeout expected drained");
        else passes++;
        for (int f = 0; f < FLUX; f++) begin
            checks++;
            if (got_out[f].size() !== exp_out[f].size() || got_ext[f].size() !== exp_ext[f].size())
                $display("[TB] FAIL reset_counts flux%0d: got %0d/%0d expected %0d/%0d", f,
                         got_out[f].size(), got_ext[f].size(), exp_out[f].size(), exp_ext[f].size());
            else passes++;
            for (int i = 0; i < got_out[f].size() && i < exp_out[f].size(); i++) begin
                checks++;
                if (got_out[f][i] !== exp_out[f][i]) begin
                    $display("[TB] FAIL reset_out flux%0d[%0d]: got %0d expected %0d", f, i, got_out[f][i], exp_out[f][i]);
                    break;
                end
                passes++;
            end
        end
    endtask

    task automatic test_basic();
        bit ok;
        clear_all();
        applyStimulus(0, 4, 10);
        wait_drained(300, ok);
        checks++;
        if (!ok) $display("[TB] FAIL basic_drain: got timeout expected drained");
        else passes++;
        checks++;
        if (got_ext[0].size() !== 1 || got_ext[0][0] !== 7'd11)
            $display("[TB] FAIL basic_ext: got count %0d first %0d expected 1 x 11", got_ext[0].size(),
                     (got_ext[0].size() > 0) ? int'(got_ext[0][0]) : -1);
        else passes++;
        checks++;
        if (got_out[0].size() !== 44 || got_out[1].size() !== 0)
            $display("[TB] FAIL basic_count: got %0d/%0d expected 44/0", got_out[0].size(), got_out[1].size());
        else passes++;
        for (int i = 0; i < got_out[0].size() && i < exp_out[0].size(); i++) begin
            checks++;
            if (got_out[0][i] !== exp_out[0][i]) begin
                $display("[TB] FAIL basic_out[%0d]: got %0d expected %0d", i, got_out[0][i], exp_out[0][i]);
                break;
            end
            passes++;
        end
        checks++;
        if (last_out[0] - first_size_rd[0] + 1 !== 1 + 4 * (4 + PAD_L + PAD_R))
            $display("[TB] FAIL basic_throughput: got %0d cycles expected %0d",
                     last_out[0] - first_size_rd[0] + 1, 1 + 4 * (4 + PAD_L + PAD_R));
        else passes++;
    endtask

    task automatic test_priority();
        bit ok;
        clear_all();
        for (int b = 0; b < 2; b++) begin
            applyStimulus(0, $urandom_range(2, 5), -1);
            applyStimulus(1, $urandom_range(2, 5), -1);
        end
        wait_drained(1000, ok);
        checks++;
        if (!ok) $display("[TB] FAIL prio_drain: got timeout expected drained");
        else passes++;
        checks++;
        if (first_act[1] <= last_act[0])
            $display("[TB] FAIL prio_order: flux1 first cycle %0d expected after flux0 last %0d",
                     first_act[1], last_act[0]);
        else passes++;
        for (int f = 0; f < FLUX; f++) begin
            checks++;
            if (got_out[f].size() !== exp_out[f].size() || got_ext[f].size() !== exp_ext[f].size())
                $display("[TB] FAIL prio_counts flux%0d: got %0d/%0d expected %0d/%0d", f,
                         got_out[f].size(), got_ext[f].size(), exp_out[f].size(), exp_ext[f].size());
            else passes++;
            for (int i = 0; i < got_ext[f].size() && i < exp_ext[f].size(); i++) begin
                checks++;
                if (got_ext[f][i] !== exp_ext[f][i]) begin
                    $display("[TB] FAIL prio_ext flux%0d[%0d]: got %0d expected %0d", f, i, got_ext[f][i], exp_ext[f][i]);
                    break;
                end
                passes++;
            end
            for (int i = 0; i < got_out[f].size() && i < exp_out[f].size(); i++) begin
                checks++;
                if (got_out[f][i] !== exp_out[f][i]) begin
                    $display("[TB] FAIL prio_out flux%0d[%0d]: got %0d expected %0d", f, i, got_out[f][i], exp_out[f][i]);
                    break;
                end
                passes++;
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        int held;
        clear_all();
        applyStimulus(0, 5, -1);
        for (int i = 0; i < 100 && got_out[0].size() < 5; i++) begin
            @(posedge clk);
            #2;
        end
        full_force[0] = 1'b1;
        @(posedge clk);
        #2;
        held = got_out[0].size();
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (pel_if.read[0] !== 1'b0 || out_if.write !== 1'b0)
                $display("[TB] FAIL stall_strobes: pel_read %b out_write %b expected 0 0", pel_if.read[0], out_if.write);
            else passes++;
        end
        @(posedge clk);
        #2;
        checks++;
        if (got_out[0].size() !== held)
            $display("[TB] FAIL stall_hold: got %0d writes expected %0d", got_out[0].size(), held);
        else passes++;
        full_force[0] = 1'b0;
        wait_drained(300, ok);
        checks++;
        if (!ok) $display("[TB] FAIL stall_drain: got timeout expected drained");
        else passes++;
        checks++;
        if (got_out[0].size() !== exp_out[0].size())
            $display("[TB] FAIL stall_count: got %0d expected %0d", got_out[0].size(), exp_out[0].size());
        else passes++;
        for (int i = 0; i < got_out[0].size() && i < exp_out[0].size(); i++) begin
            checks++;
            if (got_out[0][i] !== exp_out[0][i]) begin
                $display("[TB] FAIL stall_out[%0d]: got %0d expected %0d", i, got_out[0][i], exp_out[0][i]);
                break;
            end
            passes++;
        end
    endtask

    task automatic test_size_edges();
        bit ok;
        clear_all();
        applyStimulus(1, 0, -1);
        applyStimulus(1, 1, -1);
        applyStimulus(1, 127, -1);
        wait_drained(20000, ok);
        checks++;
        if (!ok) $display("[TB] FAIL edge_drain: got timeout expected drained");
        else passes++;
        checks++;
        if (got_ext[1].size() !== 2)
            $display("[TB] FAIL edge_ext_count: got %0d expected 2", got_ext[1].size());
        else passes++;
        checks++;
        if (got_ext[1].size() < 2 || got_ext[1][0] !== 7'd8 || got_ext[1][1] !== 7'd127)
            $display("[TB] FAIL edge_ext_values: got %0d,%0d expected 8,127",
                     (got_ext[1].size() > 0) ? int'(got_ext[1][0]) : -1,
                     (got_ext[1].size() > 1) ? int'(got_ext[1][1]) : -1);
        else passes++;
        checks++;
        if (got_out[1].size() !== 8 + 120 * 127)
            $display("[TB] FAIL edge_count: got %0d expected %0d", got_out[1].size(), 8 + 120 * 127);
        else passes++;
        for (int i = 0; i < got_out[1].size() && i < exp_out[1].size(); i++) begin
            checks++;
            if (got_out[1][i] !== exp_out[1][i]) begin
                $display("[TB] FAIL edge_out[%0d]: got %0d expected %0d", i, got_out[1][i], exp_out[1][i]);
                break;
            end
            passes++;
        end
    endtask

    task automatic test_reset_mid_block();
        bit ok;
        clear_all();
        applyStimulus(0, 4, -1);
        for (int i = 0; i < 200 && got_out[0].size() < 30; i++) begin
            @(posedge clk);
            #2;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({size_if.read, pel_if.read, out_if.write, ext_if.write} !== 6'b0)
            $display("[TB] FAIL midrst_strobes: got %b expected 000000",
                     {size_if.read, pel_if.read, out_if.write, ext_if.write});
        else passes++;
        @(posedge clk);
        #2;
        rst = 1'b0;
        checks++;
        if (pel_q[0].size() !== 4)
            $display("[TB] FAIL midrst_left_pels: got %0d expected 4", pel_q[0].size());
        else passes++;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (pel_if.read[0] !== 1'b0 || out_if.write !== 1'b0)
                $display("[TB] FAIL midrst_idle: pel_read %b out_write %b expected 0 0", pel_if.read[0], out_if.write);
            else passes++;
        end
        @(posedge clk);
        #2;
        clear_all();
        applyStimulus(0, 2, -1);
        wait_drained(200, ok);
        checks++;
        if (!ok) $display("[TB] FAIL midrst_drain: got timeout expected drained");
        else passes++;
        checks++;
        if (got_ext[0].size() !== 1 || got_ext[0][0] !== 7'd9)
            $display("[TB] FAIL midrst_ext: got count %0d expected 1 x 9", got_ext[0].size());
        else passes++;
        for (int i = 0; i < got_out[0].size() && i < exp_out[0].size(); i++) begin
            checks++;
            if (got_out[0][i] !== exp_out[0][i]) begin
                $display("[TB] FAIL midrst_out[%0d]: got %0d expected %0d", i, got_out[0][i], exp_out[0][i]);
                break;
            end
            passes++;
        end
    endtask

    task automatic test_random();
        bit ok;
        clear_all();
        for (int b = 0; b < 4; b++) begin
            applyStimulus(0, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 9), -1);
            applyStimulus(1, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 9), -1);
        end
        rand_stall = 1'b1;
        wait_drained(8000, ok);
        rand_stall = 1'b0;
        checks++;
        if (!ok) $display("[TB] FAIL random_drain: got timeout expected drained");
        else passes++;
        for (int f = 0; f < FLUX; f++) begin
            checks++;
            if (got_out[f].size() !== exp_out[f].size() || got_ext[f].size() !== exp_ext[f].size())
                $display("[TB] FAIL random_counts flux%0d: got %0d/%0d expected %0d/%0d", f,
                         got_out[f].size(), got_ext[f].size(), exp_out[f].size(), exp_ext[f].size());
            else passes++;
            for (int i = 0; i < got_ext[f].size() && i < exp_ext[f].size(); i++) begin
                checks++;
                if (got_ext[f][i] !== exp_ext[f][i]) begin
                    $display("[TB] FAIL random_ext flux%0d[%0d]: got %0d expected %0d", f, i, got_ext[f][i], exp_ext[f][i]);
                    break;
                end
                passes++;
            end
            for (int i = 0; i < got_out[f].size() && i < exp_out[f].size(); i++) begin
                checks++;
                if (got_out[f][i] !== exp_out[f][i]) begin
                    $display("[TB] FAIL random_out flux%0d[%0d]: got %0d expected %0d", f, i, got_out[f][i], exp_out[f][i]);
                    break;
                end
                passes++;
            end
        end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_stall();
        test_size_edges();
        test_reset_mid_block();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
